// File: rtl/vm_pkg.sv
// Shared vending-machine definitions.
// Holds the coin_type encodings, the coin values in cents, the change
// dispenser state enum and a coin-to-value helper. The vend FSM imports
// this package as well, so it keeps the encodings identical across blocks.
package vm_pkg;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_DONE
  } disp_state_e;

  localparam logic [7:0] VAL_NICKEL  = 8'd5;
  localparam logic [7:0] VAL_DIME    = 8'd10;
  localparam logic [7:0] VAL_QUARTER = 8'd25;

  function automatic logic [7:0] coin_value(input coin_e c);
    case (c)
      COIN_NICKEL:  coin_value = VAL_NICKEL;
      COIN_DIME:    coin_value = VAL_DIME;
      COIN_QUARTER: coin_value = VAL_QUARTER;
      default:      coin_value = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/ack_timer.sv
// Coin-acknowledge watchdog.
// A loadable down-counter. The dispenser loads it while it picks a coin. It
// then counts down once per cycle while the request is outstanding. It
// reports expiry on the cycle that completes TIMEOUT waiting cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : preload the counter (asserted while picking a coin)
//   run        : count down (asserted while waiting for coin_ack)
//   expired    : counter has reached zero
// TIMEOUT must be at least 1.
module ack_timer #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking (<=) so every flop samples
  // pre-edge values regardless of the order of always blocks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      // Loading TIMEOUT-1 means the sampled value is zero on the
      // TIMEOUT-th edge spent waiting.
      count <= W'(TIMEOUT - 1);
    end else if (run && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser controller.
// Pays out change_amt cents one coin at a time. It chooses coins greedily
// (quarter, dime, nickel) from the per-type stock counters. It handshakes
// each coin with the mechanism through coin_req/coin_ack. The job ends
// with a one-cycle done pulse. short is valid with done and is high when
// the full amount was not paid.
//   start/change_amt   : begin a job (accepted only in IDLE)
//   abort              : end the current job early
//   refill             : restock all coin types, clear fault (IDLE only)
//   coin_req/coin_type : request one coin of the given type
//   coin_ack           : mechanism ejected the requested coin
//   busy, done, short  : job status
//   fault              : sticky ack-timeout flag
//   remain             : cents still owed
//   stock_q/d/n        : coins left per type
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned STOCK_INIT  = 8,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] change_amt,
  input  logic       abort,
  input  logic       refill,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic [1:0] coin_type,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic       fault,
  output logic [7:0] remain,
  output logic [7:0] stock_q,
  output logic [7:0] stock_d,
  output logic [7:0] stock_n
);

  localparam logic [7:0] STOCK_FULL = 8'(STOCK_INIT);

  disp_state_e state;
  coin_e       cur_coin;
  coin_e       pick;
  logic [7:0]  remain_paid;
  logic        timer_expired;

  ack_timer #(
    .TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state == ST_SELECT),
    .run    (state == ST_REQ),
    .expired(timer_expired)
  );

  // The greedy choice only picks a coin whose value fits in remain.
  // This keeps remain from underflowing.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    pick = COIN_NONE;
    if (remain >= VAL_QUARTER && stock_q != 8'd0) begin
      pick = COIN_QUARTER;
    end else if (remain >= VAL_DIME && stock_d != 8'd0) begin
      pick = COIN_DIME;
    end else if (remain >= VAL_NICKEL && stock_n != 8'd0) begin
      pick = COIN_NICKEL;
    end
  end

  assign remain_paid = remain - coin_value(cur_coin);
  assign coin_type   = cur_coin;
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur_coin <= COIN_NONE;
      coin_req <= 1'b0;
      done     <= 1'b0;
      short    <= 1'b0;
      fault    <= 1'b0;
      remain   <= 8'd0;
      stock_q  <= STOCK_FULL;
      stock_d  <= STOCK_FULL;
      stock_n  <= STOCK_FULL;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (refill) begin
            stock_q <= STOCK_FULL;
            stock_d <= STOCK_FULL;
            stock_n <= STOCK_FULL;
            fault   <= 1'b0;
          end
          if (start) begin
            remain <= change_amt;
            short  <= 1'b0;
            state  <= ST_SELECT;
          end
        end

        ST_SELECT: begin
          if (abort || pick == COIN_NONE) begin
            // A zero balance also yields COIN_NONE and ends the job unshort.
            state <= ST_DONE;
            done  <= 1'b1;
            short <= (remain != 8'd0);
          end else begin
            cur_coin <= pick;
            coin_req <= 1'b1;
            state    <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (coin_ack) begin
            // The coin is accounted even if abort arrives in the same cycle.
            remain   <= remain_paid;
            coin_req <= 1'b0;
            cur_coin <= COIN_NONE;
            case (cur_coin)
              COIN_QUARTER: if (stock_q != 8'd0) stock_q <= stock_q - 8'd1;
              COIN_DIME:    if (stock_d != 8'd0) stock_d <= stock_d - 8'd1;
              COIN_NICKEL:  if (stock_n != 8'd0) stock_n <= stock_n - 8'd1;
              default:      ;
            endcase
            if (abort) begin
              state <= ST_DONE;
              done  <= 1'b1;
              short <= (remain_paid != 8'd0);
            end else begin
              state <= ST_SELECT;
            end
          end else if (abort) begin
            coin_req <= 1'b0;
            cur_coin <= COIN_NONE;
            state    <= ST_DONE;
            done     <= 1'b1;
            short    <= (remain != 8'd0);
          end else if (timer_expired) begin
            coin_req <= 1'b0;
            cur_coin <= COIN_NONE;
            fault    <= 1'b1;
            state    <= ST_DONE;
            done     <= 1'b1;
            short    <= 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter STOCK_INIT, default 8: coins of each type loaded at reset and on refill.
REQ-002 Parameter ACK_TIMEOUT, default 1000: maximum cycles to wait for coin_ack before fault.
REQ-003 clk  in  1  system clock, 100 MHz; all logic on rising edge.
REQ-004 rst_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-005 start  in  1  one-cycle pulse from vend FSM: dispense change_amt.
REQ-006 change_amt  in  8  change owed in cents; sampled only on accepted start.
REQ-007 abort  in  1  stop dispensing (service/cancel); level, sampled each cycle.
REQ-008 refill  in  1  pulse: reload all stock counters to STOCK_INIT.
REQ-009 coin_ack  in  1  dispenser mechanism confirms one coin ejected.
REQ-010 coin_req  out  1  request one coin of coin_type.
REQ-011 coin_type  out  2  00 none, 01 nickel (5c), 10 dime (10c), 11 quarter (25c).
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse at end of every dispense job.
REQ-014 short  out  1  valid with done: change not fully paid.
REQ-015 fault  out  1  sticky: ack timeout occurred; cleared only by reset or refill.
REQ-016 remain  out  8  cents still owed; live during job, held after done.
REQ-017 stock_q, stock_d, stock_n  out  8 each  coins left per type.

Function
REQ-018 States IDLE, SELECT, REQ, DONE; DONE lasts exactly one cycle then returns to IDLE.
REQ-019 IDLE: start=1 latches remain<=change_amt and goes to SELECT next cycle; start while busy is ignored.
REQ-020 SELECT (one cycle): choose quarter if remain>=25 and stock_q>0, else dime if remain>=10 and stock_d>0, else nickel if remain>=5 and stock_n>0; chosen type registered onto coin_type, go REQ.
REQ-021 SELECT with remain==0 goes DONE with short=0; with remain>0 and no eligible coin goes DONE with short=1 (covers non-multiple-of-5 residue and empty stock).
REQ-022 REQ: coin_req=1 and coin_type stable until coin_ack sampled high; coin_req first asserts the cycle after entering REQ's SELECT decision (start-to-coin_req latency = 2 cycles).
REQ-023 On coin_ack in REQ: remain -= coin value, matching stock decrements by 1, coin_req drops next cycle, go SELECT.
REQ-024 coin_ack outside REQ is ignored; no counter changes.
REQ-025 abort high in SELECT or REQ (without same-cycle coin_ack) goes DONE with short=(remain>0); coin_req drops next cycle.
REQ-026 abort and coin_ack same cycle in REQ: coin is accounted (REQ-023), then DONE with short=(updated remain>0).
REQ-027 REQ counts cycles waiting; at ACK_TIMEOUT cycles without ack: fault<=1, go DONE with short=1, no stock change.
REQ-028 refill honored only in IDLE (stocks<=STOCK_INIT, fault<=0); ignored while busy.
REQ-029 Stock counters never wrap below 0; remain never underflows (coin only chosen if value<=remain).
REQ-030 coin_type=00 in IDLE and DONE.

Reset
REQ-031 rst_n=0 at any clock edge, including mid-job: state IDLE, coin_req=0, coin_type=00, busy=0, done=0, short=0, fault=0, remain=0, all stocks=STOCK_INIT, timeout counter=0.
REQ-032 Reset mid-job discards the job; no done pulse is produced for it.

Structure
REQ-033 Shared package vm_pkg holds coin_type encodings, coin values (5/10/25), and the state enum; also used by the vend FSM.
REQ-034 One sub-module, ack_timer: loadable down-counter started on REQ entry, reports expiry; all else in change_dispenser.

Verification
REQ-035 Reset, start change_amt=15, ack each req after 3 cycles -> dime then nickel, done with short=0, remain=0, stock_d=7, stock_n=7.
REQ-036 change_amt=0 -> done 2 cycles after start, short=0, coin_req never asserted.
REQ-037 STOCK_INIT=8, change_amt=255, ack immediately -> 8 quarters, 5 dimes (5c residue pays nickel), done short=0; repeat job -> greedy uses dimes/nickels, ends short=1 when stocks exhausted.
REQ-038 change_amt=7 -> one nickel, then done short=1, remain=2.
REQ-039 Hold coin_ack=0 -> done short=1 and fault=1 exactly ACK_TIMEOUT cycles after coin_req rises; refill in IDLE clears fault.
REQ-040 Abort same cycle as ack on first quarter of 50c job -> done short=1, remain=25, stock_q=7; rst_n low mid-REQ -> coin_req=0 next cycle, no done.
